// File: rtl/fan_uptime_counter_pkg.sv
// Shared constants for the BCD elapsed-time format {hour,min10,min1,sec10,sec1}.
package fan_uptime_counter_pkg;

   localparam int SEC1_LSB   = 0;
   localparam int SEC10_LSB  = 4;
   localparam int MIN1_LSB   = 8;
   localparam int MIN10_LSB  = 12;
   localparam int HOUR_LSB   = 16;

   localparam int MOD_SEC1   = 10;
   localparam int MOD_SEC10  = 6;
   localparam int MOD_MIN1   = 10;
   localparam int MOD_MIN10  = 6;
   localparam int MOD_HOUR   = 10;

   localparam int          NUM_DIGITS = 5;
   localparam logic [19:0] MAX_TIME   = 20'h95959;

   // Digit index 0 is sec1, 4 is hour.
   function automatic int digit_mod(input int idx);
      case (idx)
         0:       return MOD_SEC1;
         1:       return MOD_SEC10;
         2:       return MOD_MIN1;
         3:       return MOD_MIN10;
         default: return MOD_HOUR;
      endcase
   endfunction

   function automatic int digit_lsb(input int idx);
      case (idx)
         0:       return SEC1_LSB;
         1:       return SEC10_LSB;
         2:       return MIN1_LSB;
         3:       return MIN10_LSB;
         default: return HOUR_LSB;
      endcase
   endfunction

endpackage

// File: rtl/fan_uptime_counter_bcd_up_digit.sv
// One modulo-N BCD digit of the uptime chain; carry fires when it wraps.
module bcd_up_digit
   import fan_uptime_counter_pkg::*;
#(
   parameter int N = 10
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   localparam logic [3:0] DMAX = 4'(N - 1);

   logic [3:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr)
         digit_d = '0;
      else if (inc)
         digit_d = (digit_q == DMAX) ? 4'd0 : digit_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset_p)
         digit_q <= '0;
      else
         digit_q <= digit_d;
   end

   assign digit = digit_q;
   assign carry = inc && (digit_q == DMAX);

endmodule

// File: rtl/fan_uptime_counter.sv
// Up-counting BCD fan run-time meter with saturation at 9:59:59 and a limit-reached pulse.
module fan_uptime_counter
   import fan_uptime_counter_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        run_e,
   input  logic        clear,
   input  logic        limit_en,
   input  logic [19:0] limit_bcd,
   output logic [19:0] cur_time,
   output logic        sec_tick,
   output logic        limit_pedge,
   output logic        overflow
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]       pre_q, pre_d;
   logic                ovf_q, ovf_d;
   logic                tick_q, tick_d;
   logic                match_q, pedge_q, match;
   logic                tc, at_max, adv;
   logic [19:0]         time_w;
   logic [NUM_DIGITS:0] inc_c;
   logic                hour_carry_unused;

   assign tc     = run_e && !ovf_q && (pre_q == PRE_MAX);
   assign at_max = (time_w == MAX_TIME);
   // Chain only advances on an unsaturated tick; clear always wins.
   assign adv    = tc && !at_max && !clear;
   assign match  = limit_en && (time_w == limit_bcd);

   assign inc_c[0] = adv;
   // Hour carry cannot happen: the chain is held at max time instead of wrapping.
   assign hour_carry_unused = inc_c[NUM_DIGITS];

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_up_digit #(.N(digit_mod(g))) u_digit (
         .clk     (clk),
         .reset_p (reset_p),
         .clr     (clear),
         .inc     (inc_c[g]),
         .digit   (time_w[digit_lsb(g) +: 4]),
         .carry   (inc_c[g+1])
      );
   end

   always_comb begin
      pre_d  = pre_q;
      ovf_d  = ovf_q;
      tick_d = adv;
      if (clear) begin
         pre_d = '0;
         ovf_d = 1'b0;
      end else if (run_e && !ovf_q) begin
         pre_d = tc ? '0 : pre_q + PW'(1);
         if (tc && at_max)
            ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         pre_q   <= '0;
         ovf_q   <= 1'b0;
         tick_q  <= 1'b0;
         match_q <= 1'b0;
         pedge_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         ovf_q   <= ovf_d;
         tick_q  <= tick_d;
         match_q <= match;
         pedge_q <= match && !match_q;
      end
   end

   assign cur_time    = time_w;
   assign sec_tick    = tick_q;
   assign limit_pedge = pedge_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_fan_uptime_counter.sv
// Bench: main DUT (TICK_DIV=4) against a seconds-based reference model; a TICK_DIV=1 DUT for saturation.
module tb_fan_uptime_counter;

   localparam int DIV     = 4;
   localparam int MAX_SEC = 9*3600 + 59*60 + 59;

   logic        clk;
   logic        reset_p, run_e, clear, limit_en;
   logic [19:0] limit_bcd;
   logic [19:0] cur_time;
   logic        sec_tick, limit_pedge, overflow;

   logic        r2_reset, r2_run, r2_clear;
   logic [19:0] cur_time2;
   logic        sec_tick2, limit_pedge2, overflow2;

   int n_tests = 0;
   int n_fail  = 0;

   fan_uptime_counter #(.TICK_DIV(DIV)) dut (
      .clk(clk), .reset_p(reset_p), .run_e(run_e), .clear(clear),
      .limit_en(limit_en), .limit_bcd(limit_bcd), .cur_time(cur_time),
      .sec_tick(sec_tick), .limit_pedge(limit_pedge), .overflow(overflow)
   );

   fan_uptime_counter #(.TICK_DIV(1)) dut2 (
      .clk(clk), .reset_p(r2_reset), .run_e(r2_run), .clear(r2_clear),
      .limit_en(1'b0), .limit_bcd(20'h0), .cur_time(cur_time2),
      .sec_tick(sec_tick2), .limit_pedge(limit_pedge2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] to_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Reference model: elapsed seconds as a plain integer, sub-second phase as an enabled-clock count.
   int m_phase, m_sec;
   bit m_ovf, m_tick, m_pedge, m_prev_match;

   always @(posedge clk) begin
      bit match_now;
      match_now = limit_en && (to_bcd(m_sec) == limit_bcd);
      if (reset_p) begin
         m_phase = 0; m_sec = 0; m_ovf = 0; m_tick = 0; m_pedge = 0; m_prev_match = 0;
      end else begin
         m_pedge      = match_now && !m_prev_match;
         m_prev_match = match_now;
         m_tick       = 0;
         if (clear) begin
            m_phase = 0; m_sec = 0; m_ovf = 0;
         end else if (run_e && !m_ovf) begin
            m_phase++;
            if (m_phase == DIV) begin
               m_phase = 0;
               if (m_sec == MAX_SEC) m_ovf = 1;
               else begin m_sec++; m_tick = 1; end
            end
         end
      end
   end

   task automatic test_reset();
      reset_p = 1; run_e = 1; clear = 0; limit_en = 1; limit_bcd = 20'h0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cur_time, sec_tick, limit_pedge, overflow} !== 23'h0) begin
         n_fail++;
         $display("FAIL reset: got t=%h tk=%b pe=%b ov=%b, want all 0", cur_time, sec_tick, limit_pedge, overflow);
      end
      reset_p = 0; run_e = 0; limit_en = 0;
   endtask

   task automatic test_basic_count();
      int ticks, last;
      ticks = 0; last = -1;
      run_e = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_tests++;
         if ({cur_time, sec_tick, limit_pedge, overflow} !== {to_bcd(m_sec), m_tick, m_pedge, m_ovf}) begin
            n_fail++;
            $display("FAIL basic c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, cur_time, sec_tick, limit_pedge,
                     overflow, to_bcd(m_sec), m_tick, m_pedge, m_ovf);
         end
         if (sec_tick === 1'b1) begin
            if (last >= 0) begin
               n_tests++;
               if (i - last != DIV) begin
                  n_fail++;
                  $display("FAIL tick_spacing: got %0d clks want %0d", i - last, DIV);
               end
            end
            last = i;
            ticks++;
         end
      end
      n_tests++;
      if (cur_time !== 20'h00010 || ticks != 10) begin
         n_fail++;
         $display("FAIL basic_end: got t=%h ticks=%0d want t=00010 ticks=10", cur_time, ticks);
      end
   endtask

   task automatic test_sec10_wrap();
      // from 10 s: 49 more seconds reaches 0:00:59, one more carries into min1
      repeat (49 * DIV) @(negedge clk);
      n_tests++;
      if (cur_time !== 20'h00059) begin
         n_fail++;
         $display("FAIL wrap_pre: got %h want 00059", cur_time);
      end
      repeat (DIV) @(negedge clk);
      n_tests++;
      if (cur_time !== 20'h00100 || sec_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_carry: got t=%h tk=%b want 00100/1", cur_time, sec_tick);
      end
   endtask

   task automatic test_pause();
      run_e = 0; clear = 1;
      @(negedge clk);
      clear = 0; run_e = 1;
      repeat (6) @(negedge clk);
      n_tests++;
      if (cur_time !== 20'h00001) begin
         n_fail++;
         $display("FAIL pause_run6: got %h want 00001", cur_time);
      end
      run_e = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_tests++;
         if (cur_time !== 20'h00001 || sec_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold c%0d: got t=%h tk=%b want 00001/0", i, cur_time, sec_tick);
         end
      end
      run_e = 1;
      @(negedge clk);
      n_tests++;
      if (sec_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_resume7: got tk=%b want 0", sec_tick);
      end
      @(negedge clk);
      n_tests++;
      if (cur_time !== 20'h00002 || sec_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_resume8: got t=%h tk=%b want 00002/1", cur_time, sec_tick);
      end
   endtask

   task automatic test_clear_on_tc();
      repeat (DIV - 1) @(negedge clk);
      clear = 1;
      @(negedge clk);
      clear = 0; run_e = 0;
      n_tests++;
      if (cur_time !== 20'h0 || sec_tick !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_tc: got t=%h tk=%b ov=%b want 0/0/0", cur_time, sec_tick, overflow);
      end
   endtask

   task automatic test_limit();
      int pulses, t3, tp;
      limit_bcd = 20'h00003; limit_en = 1; run_e = 1;
      pulses = 0; t3 = -1; tp = -1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (cur_time === 20'h00003 && t3 < 0) t3 = i;
         if (limit_pedge === 1'b1) begin pulses++; tp = i; end
         n_tests++;
         if (limit_pedge !== m_pedge || cur_time !== to_bcd(m_sec)) begin
            n_fail++;
            $display("FAIL limit c%0d: got t=%h pe=%b want %h/%b", i, cur_time, limit_pedge, to_bcd(m_sec), m_pedge);
         end
      end
      n_tests++;
      if (pulses != 1 || tp != t3 + 1 || t3 < 0) begin
         n_fail++;
         $display("FAIL limit_once: got pulses=%0d at %0d (eq at %0d) want 1 pulse 1 clk after eq", pulses, tp, t3);
      end
      run_e = 0; limit_en = 0;
      repeat (2) @(negedge clk);
      limit_en = 1; pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (limit_pedge === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL limit_reen: got %0d pulses want 1", pulses);
      end
      // zero limit fires right after a clear
      limit_bcd = 20'h0; clear = 1;
      @(negedge clk);
      clear = 0;
      @(negedge clk);
      n_tests++;
      if (limit_pedge !== 1'b1 || cur_time !== 20'h0) begin
         n_fail++;
         $display("FAIL limit_zero: got pe=%b t=%h want 1/00000", limit_pedge, cur_time);
      end
      limit_bcd = 20'h0000A; run_e = 1; pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (limit_pedge === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL limit_nonbcd: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_reset_mid();
      repeat ($urandom_range(10, 30)) @(negedge clk);
      limit_en = 1; limit_bcd = cur_time;
      reset_p = 1;
      @(negedge clk);
      n_tests++;
      if ({cur_time, sec_tick, limit_pedge, overflow} !== 23'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got t=%h tk=%b pe=%b ov=%b want all 0", cur_time, sec_tick, limit_pedge, overflow);
      end
      reset_p = 0; limit_en = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         run_e    = ($urandom_range(0, 9) < 8);
         clear    = ($urandom_range(0, 99) < 2);
         limit_en = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0)
            limit_bcd = ($urandom_range(0, 3) == 0) ? 20'($urandom) : to_bcd($urandom_range(0, 40));
         @(negedge clk);
         n_tests++;
         if ({cur_time, sec_tick, limit_pedge, overflow} !== {to_bcd(m_sec), m_tick, m_pedge, m_ovf}) begin
            n_fail++;
            $display("FAIL random c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, cur_time, sec_tick, limit_pedge,
                     overflow, to_bcd(m_sec), m_tick, m_pedge, m_ovf);
         end
      end
      run_e = 0; clear = 0; limit_en = 0;
   endtask

   task automatic test_saturation();
      int ticks, spot;
      ticks = 0;
      spot  = $urandom_range(4000, 35000);
      r2_reset = 0; r2_run = 1;
      for (int s = 1; s <= MAX_SEC; s++) begin
         @(negedge clk);
         if (sec_tick2 === 1'b1) ticks++;
         if (s == 3599 || s == 3600 || s == spot) begin
            n_tests++;
            if (cur_time2 !== to_bcd(s) || overflow2 !== 1'b0) begin
               n_fail++;
               $display("FAIL sat_count s=%0d: got t=%h ov=%b want %h/0", s, cur_time2, overflow2, to_bcd(s));
            end
         end
      end
      n_tests++;
      if (cur_time2 !== 20'h95959 || overflow2 !== 1'b0 || ticks != MAX_SEC) begin
         n_fail++;
         $display("FAIL sat_reach: got t=%h ov=%b ticks=%0d want 95959/0/%0d", cur_time2, overflow2, ticks, MAX_SEC);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++;
         if (cur_time2 !== 20'h95959 || overflow2 !== 1'b1 || sec_tick2 !== 1'b0 || limit_pedge2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold c%0d: got t=%h ov=%b tk=%b want 95959/1/0", i, cur_time2, overflow2, sec_tick2);
         end
      end
      r2_clear = 1;
      @(negedge clk);
      r2_clear = 0; r2_run = 0;
      n_tests++;
      if (cur_time2 !== 20'h0 || overflow2 !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_clear: got t=%h ov=%b want 00000/0", cur_time2, overflow2);
      end
   endtask

   initial begin
      reset_p = 1; run_e = 0; clear = 0; limit_en = 0; limit_bcd = 20'h0;
      r2_reset = 1; r2_run = 0; r2_clear = 0;
      test_reset();
      test_basic_count();
      test_sec10_wrap();
      test_pause();
      test_clear_on_tc();
      test_limit();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
